// File: rtl/pe_mac_stream_pkg.sv
// Shared types and helpers for the streaming MAC processing element.
// Holds the FSM state type, width helpers and the round/saturate rule.
package pe_mac_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rs_t;

  function automatic int len_bits(input int dmax);
    return $clog2(dmax + 1);
  endfunction

  function automatic int sh_bits(input int acc_bits);
    return $clog2(acc_bits);
  endfunction

  // Round-half-up right shift, then clip to an ob-bit signed range.
  function automatic rs_t round_sat(
    input logic signed [63:0] acc,
    input int unsigned        sh,
    input int                 ob
  );
    rs_t                t;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc >>> sh;
    if (sh > 0)
      r = r + ((acc >>> (sh - 1)) & 64'sd1);
    hi = (64'sd1 <<< (ob - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    t.sat = 1'b0;
    t.val = r;
    if (r > hi) begin
      t.val = hi;
      t.sat = 1'b1;
    end else if (r < lo) begin
      t.val = lo;
      t.sat = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/pe_mac_stream_if.sv
// Operand/result stream bundle of the MAC processing element.
// Signal names follow the block's port list; master drives the i_* side.
interface pe_mac_stream_if
  import pe_mac_stream_pkg::*;
#(
  parameter int I_BITS        = 8,
  parameter int DIMENSION_MAX = 8,
  parameter int O_BITS        = 16,
  parameter int ACC_BITS      =
    2*I_BITS + $clog2(DIMENSION_MAX)
);
  localparam int LEN_BITS = len_bits(DIMENSION_MAX);
  localparam int SH_BITS  = sh_bits(ACC_BITS);

  logic                       i_valid;
  logic [LEN_BITS-1:0]        i_len;
  logic [SH_BITS-1:0]         i_shift;
  logic                       i_a_reset;
  logic                       i_b_reset;
  logic signed [I_BITS-1:0]   i_a;
  logic signed [I_BITS-1:0]   i_b;
  logic                       i_c_ready;
  logic signed [I_BITS-1:0]   o_a;
  logic signed [I_BITS-1:0]   o_b;
  logic                       o_a_reset;
  logic                       o_b_reset;
  logic signed [O_BITS-1:0]   o_c;
  logic                       o_c_valid;
  logic                       o_finish;
  logic                       o_sat;
  logic                       o_ovf;

  modport master (
    output i_valid, i_len, i_shift,
    output i_a_reset, i_b_reset,
    output i_a, i_b, i_c_ready,
    input  o_a, o_b, o_a_reset, o_b_reset,
    input  o_c, o_c_valid, o_finish,
    input  o_sat, o_ovf
  );

  modport slave (
    input  i_valid, i_len, i_shift,
    input  i_a_reset, i_b_reset,
    input  i_a, i_b, i_c_ready,
    output o_a, o_b, o_a_reset, o_b_reset,
    output o_c, o_c_valid, o_finish,
    output o_sat, o_ovf
  );

endinterface

// File: rtl/pe_round_sat.sv
// Combinational round-half-up shift and signed saturation.
// Narrows the accumulator to the result width and flags clipping.
module pe_round_sat
  import pe_mac_stream_pkg::*;
#(
  parameter int ACC_BITS = 19,
  parameter int O_BITS   = 16,
  parameter int SH_BITS  = 5
) (
  input  logic signed [ACC_BITS-1:0] acc,
  input  logic [SH_BITS-1:0]         sh,
  output logic signed [O_BITS-1:0]   res,
  output logic                       sat
);
  rs_t  t;
  logic unused_hi;

  always_comb begin
    t = round_sat(64'(acc), 32'(sh), O_BITS);
  end

  assign res       = t.val[O_BITS-1:0];
  assign sat       = t.sat;
  assign unused_hi = ^t.val[63:O_BITS];

endmodule

// File: rtl/pe_mac_stream.sv
// Streaming multiply-accumulate PE with operand forwarding,
// clear tokens, and a held, rounded, saturated result.
module pe_mac_stream
  import pe_mac_stream_pkg::*;
#(
  parameter int I_BITS        = 8,
  parameter int DIMENSION_MAX = 8,
  parameter int O_BITS        = 16,
  parameter int ACC_BITS      =
    2*I_BITS + $clog2(DIMENSION_MAX)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  pe_mac_stream_if.slave bus
);
  localparam int LEN_BITS = len_bits(DIMENSION_MAX);
  localparam int SH_BITS  = sh_bits(ACC_BITS);
  localparam logic [LEN_BITS-1:0] LMAX =
    LEN_BITS'(DIMENSION_MAX);
  localparam logic [LEN_BITS-1:0] ONE =
    LEN_BITS'(1);

  state_t                     state_q, state_n;
  logic signed [ACC_BITS-1:0] acc_q, acc_n;
  logic signed [ACC_BITS-1:0] prod_x;
  logic signed [2*I_BITS-1:0] prod;
  logic [LEN_BITS-1:0]        cnt_q, cnt_n;
  logic [LEN_BITS-1:0]        len_q, len_n;
  logic [LEN_BITS-1:0]        len_eff;
  logic [SH_BITS-1:0]         sh_q, sh_n;
  logic                       clr;
  logic                       last;
  logic                       done;
  logic signed [O_BITS-1:0]   res;
  logic                       sat;

  assign clr    = bus.i_a_reset | bus.i_b_reset;
  assign prod   = bus.i_a * bus.i_b;
  assign prod_x = ACC_BITS'(prod);

  always_comb begin
    len_eff = bus.i_len;
    if (bus.i_len == '0)
      len_eff = ONE;
    else if (bus.i_len > LMAX)
      len_eff = LMAX;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    sh_n    = sh_q;
    last    = 1'b0;
    done    = 1'b0;
    if (bus.i_valid) begin
      unique case (1'b1)
        clr: begin
          acc_n = '0;
          cnt_n = '0;
        end
        !clr && state_q == IDLE: begin
          len_n = len_eff;
          sh_n  = bus.i_shift;
          acc_n = prod_x;
          cnt_n = ONE;
          last  = (len_eff == ONE);
        end
        default: begin
          acc_n = acc_q + prod_x;
          cnt_n = cnt_q + ONE;
          last  = (cnt_n == len_q);
        end
      endcase
      // A clear token always wins over completion.
      done    = last && !clr;
      state_n = (clr || last) ? IDLE : ACC;
    end
  end

  pe_round_sat #(
    .ACC_BITS (ACC_BITS),
    .O_BITS   (O_BITS),
    .SH_BITS  (SH_BITS)
  ) u_round_sat (
    .acc (acc_n),
    .sh  (sh_n),
    .res (res),
    .sat (sat)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      sh_q          <= '0;
      bus.o_a       <= '0;
      bus.o_b       <= '0;
      bus.o_a_reset <= 1'b0;
      bus.o_b_reset <= 1'b0;
      bus.o_c       <= '0;
      bus.o_c_valid <= 1'b0;
      bus.o_finish  <= 1'b0;
      bus.o_sat     <= 1'b0;
      bus.o_ovf     <= 1'b0;
    end else begin
      acc_q        <= acc_n;
      cnt_q        <= cnt_n;
      len_q        <= len_n;
      sh_q         <= sh_n;
      bus.o_finish <= done;
      if (bus.i_valid) begin
        bus.o_a_reset <= clr;
        bus.o_b_reset <= clr;
        bus.o_a       <= clr ? '0 : bus.i_a;
        bus.o_b       <= clr ? '0 : bus.i_b;
      end
      if (done) begin
        if (bus.o_c_valid && !bus.i_c_ready)
          bus.o_ovf <= 1'b1;
        bus.o_c       <= res;
        bus.o_sat     <= sat;
        bus.o_c_valid <= 1'b1;
      end else if (bus.i_c_ready) begin
        bus.o_c_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pe_mac_stream.md
PE_MAC_STREAM -- requirements
Module: pe_mac_stream

Interface
REQ-001 Parameter I_BITS, default 8: signed operand width.
REQ-002 Parameter DIMENSION_MAX, default 8: maximum accumulation length.
REQ-003 Parameter O_BITS, default 16: signed result width.
REQ-004 Parameter ACC_BITS, default 2*I_BITS+$clog2(DIMENSION_MAX): accumulator width; LEN_BITS=$clog2(DIMENSION_MAX+1), SH_BITS=$clog2(ACC_BITS).
REQ-005 One clock and one reset: the reset is asynchronous and active-high.
REQ-006 i_clock  in  1  sole clock, rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_valid  in  1  beat enable; all state except i_reset effects advances only when high.
REQ-009 i_len  in  LEN_BITS  accumulation length per result; 0 is treated as 1; values above DIMENSION_MAX clamp to DIMENSION_MAX.
REQ-010 i_shift  in  SH_BITS  right-shift applied to the accumulator before rounding.
REQ-011 i_a_reset, i_b_reset  in  1 each  clear tokens travelling with the operands.
REQ-012 i_a, i_b  in  I_BITS each  signed operands.
REQ-013 i_c_ready  in  1  downstream accepts o_c.
REQ-014 o_a, o_b  out  I_BITS each  registered operand forwarding.
REQ-015 o_a_reset, o_b_reset  out  1 each  registered OR of the clear tokens.
REQ-016 o_c  out  O_BITS  held result; o_c_valid  out  1  result pending.
REQ-017 o_finish  out  1  one-cycle pulse on result completion.
REQ-018 o_sat  out  1  current o_c was saturated; o_ovf  out  1  sticky, result lost.

Function
REQ-019 FSM states IDLE and ACC; IDLE->ACC on a valid non-clear beat; ACC->IDLE on the final beat unless the next valid beat immediately starts a new run.
REQ-020 On the first beat of a run, the block latches the effective i_len into len_q and sets acc to the full-precision product i_a*i_b and cnt to 1.
REQ-021 On later beats, acc becomes acc+i_a*i_b and cnt becomes cnt+1; i_len and i_shift changes mid-run have no effect on the run.
REQ-022 The final beat is the beat where cnt reaches len_q; the next beat always starts a new run, so back-to-back runs have no bubble.
REQ-023 Result rule: r = (acc >>> sh) + (sh>0 ? acc[sh-1] : 0), round-half-up, where sh is i_shift latched at run start; r saturates to [-2^(O_BITS-1), 2^(O_BITS-1)-1], and o_sat is set when clipping occurs.
REQ-024 Latency: o_c, o_c_valid=1 and o_finish=1 appear on the clock edge after the final beat; o_finish is high for exactly one cycle.
REQ-025 o_c_valid stays high and o_c stays stable until a cycle in which i_c_ready=1, which clears o_c_valid; if a new result and i_c_ready coincide, the new result loads and o_c_valid stays high.
REQ-026 A completion while o_c_valid=1 and i_c_ready=0 overwrites o_c and sets o_ovf; o_ovf stays set until reset.
REQ-027 On a valid beat where i_a_reset|i_b_reset=1, acc, cnt, o_a and o_b go to 0 and the FSM goes to IDLE; o_c, o_c_valid and o_ovf are unaffected.
REQ-028 If a clear token and a final beat coincide, the clear wins and no result is produced.
REQ-029 o_a_reset and o_b_reset register the OR of the clear tokens on every valid beat.
REQ-030 With i_valid=0, all registers hold their values; o_finish is 0, and i_c_ready still clears o_c_valid.

Reset
REQ-031 While i_reset=1, all outputs are 0 immediately (asynchronously), the FSM is IDLE, and acc, cnt, len_q and sh are 0.
REQ-032 Reset asserted mid-run discards the partial sum; the first valid beat after release starts a new run.

Structure
REQ-033 The shared package holds the FSM state typedef, the LEN_BITS/SH_BITS width functions and the saturate/round function.
REQ-034 One sub-module, pe_round_sat (ACC_BITS in, O_BITS out, shift input, sat flag), is instantiated once.

Verification
REQ-035 i_len=4, i_shift=0, a=b=2 on four beats: one cycle after the 4th beat, o_c=16, o_finish=1 and o_c_valid=1.
REQ-036 i_shift=2 with acc=6: o_c=2; with acc=-6: o_c=-1; o_sat=0 in both cases.
REQ-037 i_len=8, a=b=-128 on eight beats (acc=131072): o_c=32767 and o_sat=1.
REQ-038 Two back-to-back i_len=2 runs with i_c_ready=0: o_c equals the second result, o_ovf=1, and no bubble occurs between the runs.
REQ-039 Clear token on beat 3 of an i_len=4 run, then four beats of a=b=1: o_c=4, and o_a_reset is high for one beat, one cycle late.
REQ-040 i_reset asserted mid-run between clock edges: all outputs go to 0 before the next edge; after release, an i_len=1 beat with a=3, b=5 gives o_c=15.
